// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares the byte-wide RAM/IO bus between fetch, load and store
//               ports, serialising 1/2/4-byte requests into byte cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_abort,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_len,
    output logic        ld_done,
    output logic [31:0] ld_rdata,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [2:0]  st_len,
    input  logic [31:0] st_wdata,
    output logic        st_done,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    localparam int               C_SW          = $clog2(STARVE_LIMIT + 1);
    localparam logic [C_SW-1:0]  C_STARVE_MAX  = C_SW'(STARVE_LIMIT);
    localparam logic [1:0]       C_IDLE        = 2'd0;
    localparam logic [1:0]       C_READ        = 2'd1;
    localparam logic [1:0]       C_WRITE       = 2'd2;
    localparam logic [1:0]       C_PORT_IF     = 2'd0;
    localparam logic [1:0]       C_PORT_LD     = 2'd1;
    localparam logic [1:0]       C_PORT_ST     = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [1:0]       port_q,     port_d;
    logic [2:0]       cnt_q,      cnt_d;
    logic [2:0]       len_q,      len_d;
    logic [31:0]      addr_q,     addr_d;
    logic [31:0]      wdata_q,    wdata_d;
    logic [31:0]      buf_q,      buf_d;
    logic [C_SW-1:0]  starve_q,   starve_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      ld_rdata_q, ld_rdata_d;

    logic        w_fetch_ok;
    logic        w_gnt_if;
    logic        w_gnt_ld;
    logic        w_gnt_st;
    logic        w_gnt_any;
    logic [31:0] w_gnt_addr;
    logic [2:0]  w_gnt_len;
    logic        w_last;
    logic [2:0]  w_idx;
    logic [31:0] w_base;
    logic [31:0] w_cur_addr;
    logic [31:0] w_wsrc;
    logic        w_wr_active;
    logic        w_io_stall;
    logic [1:0]  w_cap_idx;
    logic [31:0] w_cap_buf;
    logic        w_rd_done;

    // Any length code other than 1 or 2 means a full word.
    function automatic logic [2:0] f_len(input logic [2:0] len);
        case (len)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= C_IDLE;
            port_q     <= C_PORT_IF;
            cnt_q      <= 3'd0;
            len_q      <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            buf_q      <= 32'd0;
            starve_q   <= '0;
            if_rdata_q <= 32'd0;
            ld_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            ld_rdata_q <= ld_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Grant decode (only meaningful in IDLE while running)
    // ------------------------------------------------------------------
    always_comb begin
        w_fetch_ok = if_req & ~if_abort;
        w_gnt_if   = 1'b0;
        w_gnt_ld   = 1'b0;
        w_gnt_st   = 1'b0;
        if (rdy_in && state_q == C_IDLE) begin
            if (w_fetch_ok && starve_q == C_STARVE_MAX) begin
                w_gnt_if = 1'b1;
            end else if (st_req) begin
                w_gnt_st = 1'b1;
            end else if (ld_req) begin
                w_gnt_ld = 1'b1;
            end else if (w_fetch_ok) begin
                w_gnt_if = 1'b1;
            end
        end
        w_gnt_any  = w_gnt_if | w_gnt_ld | w_gnt_st;
        w_gnt_addr = w_gnt_st ? st_addr : (w_gnt_ld ? ld_addr : if_addr);
        w_gnt_len  = w_gnt_st ? f_len(st_len) : (w_gnt_ld ? f_len(ld_len) : 3'd4);
    end

    // ------------------------------------------------------------------
    // Current byte address, IO stall and read-byte capture
    // ------------------------------------------------------------------
    always_comb begin
        w_last = (cnt_q == len_q);
        w_idx  = 3'd0;
        case (state_q)
            // While frozen, keep presenting the byte still to be captured so
            // mem_din is correct again on the first cycle after resuming.
            C_READ:  w_idx = (!rdy_in || w_last) ? (cnt_q - 3'd1) : cnt_q;
            C_WRITE: w_idx = w_last ? (cnt_q - 3'd1) : cnt_q;
            default: w_idx = 3'd0;
        endcase
        w_base      = (state_q == C_IDLE) ? w_gnt_addr : addr_q;
        w_cur_addr  = w_base + {29'd0, w_idx};
        w_wsrc      = (state_q == C_IDLE) ? st_wdata : wdata_q;
        w_wr_active = w_gnt_st | ((state_q == C_WRITE) & ~w_last);
        w_io_stall  = w_wr_active & (w_cur_addr[17:16] == 2'b11) & io_buffer_full;

        w_cap_idx = cnt_q[1:0] - 2'd1;
        w_cap_buf = buf_q;
        w_cap_buf[{w_cap_idx, 3'b000} +: 8] = mem_din;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        ld_rdata_d = ld_rdata_q;

        if (rdy_in) begin
            if (!if_req || w_gnt_if) begin
                starve_d = '0;
            end else if ((w_gnt_st || w_gnt_ld) && starve_q != C_STARVE_MAX) begin
                starve_d = starve_q + C_SW'(1);
            end

            case (state_q)
                C_IDLE: begin
                    if (w_gnt_any) begin
                        addr_d  = w_gnt_addr;
                        len_d   = w_gnt_len;
                        wdata_d = st_wdata;
                        buf_d   = 32'd0;
                        if (w_gnt_st) begin
                            port_d  = C_PORT_ST;
                            state_d = C_WRITE;
                            cnt_d   = w_io_stall ? 3'd0 : 3'd1;
                        end else begin
                            port_d  = w_gnt_ld ? C_PORT_LD : C_PORT_IF;
                            state_d = C_READ;
                            cnt_d   = 3'd1;
                        end
                    end
                end
                C_READ: begin
                    if (port_q == C_PORT_IF && if_abort) begin
                        state_d = C_IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        buf_d = w_cap_buf;
                        if (w_last) begin
                            state_d = C_IDLE;
                            cnt_d   = 3'd0;
                            if (port_q == C_PORT_IF) begin
                                if_rdata_d = w_cap_buf;
                            end else begin
                                ld_rdata_d = w_cap_buf;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                C_WRITE: begin
                    if (w_last) begin
                        state_d = C_IDLE;
                        cnt_d   = 3'd0;
                    end else if (!w_io_stall) begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = C_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_done = rdy_in & (state_q == C_READ) & w_last;
        if_done   = w_rd_done & (port_q == C_PORT_IF) & ~if_abort;
        ld_done   = w_rd_done & (port_q == C_PORT_LD);
        st_done   = rdy_in & (state_q == C_WRITE) & w_last;
        if_rdata  = if_done ? w_cap_buf : if_rdata_q;
        ld_rdata  = ld_done ? w_cap_buf : ld_rdata_q;

        mem_wr    = rdy_in & w_wr_active & ~w_io_stall;
        mem_a     = (w_io_stall || (state_q == C_IDLE && !w_gnt_any)) ? 32'd0 : w_cur_addr;
        mem_dout  = (w_wr_active && !w_io_stall) ? w_wsrc[{w_idx[1:0], 3'b000} +: 8] : 8'd0;
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Scoreboard bench for mem_bus_arbiter with a registered RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_bus_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, io_buffer_full;
    logic        if_req, if_abort, if_done;
    logic [31:0] if_addr, if_rdata;
    logic        ld_req, ld_done;
    logic [31:0] ld_addr, ld_rdata;
    logic [2:0]  ld_len;
    logic        st_req, st_done;
    logic [31:0] st_addr, st_wdata;
    logic [2:0]  st_len;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    always #5 clk_in = ~clk_in;

    mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort), .if_done(if_done), .if_rdata(if_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done), .ld_rdata(ld_rdata),
        .st_req(st_req), .st_addr(st_addr), .st_len(st_len), .st_wdata(st_wdata), .st_done(st_done),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    // RAM contents: word 0x13 at 0x100, otherwise low address byte ^ 0x5A.
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (a == 32'h100)                     return 8'h13;
        if (a >= 32'h101 && a <= 32'h103)     return 8'h00;
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk_in) mem_din <= ram_rd(mem_a);

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    localparam int K_WR = 0;
    localparam int K_IF = 1;
    localparam int K_LD = 2;
    localparam int K_ST = 3;

    typedef struct {
        int          kind;
        int          at;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];

    task automatic push(input int kind, input int at, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.kind = kind; e.at = at; e.addr = addr; e.data = data;
        sbq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic sb_check(input int kind, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected at cycle %0d: kind=%0d addr=%h data=%h, expected nothing",
                     cyc, kind, addr, data);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.at != cyc || e.addr !== addr || e.data !== data) begin
                failures++;
                $display("FAIL sb_event: got kind=%0d cycle=%0d addr=%h data=%h, expected kind=%0d cycle=%0d addr=%h data=%h",
                         kind, cyc, addr, data, e.kind, e.at, e.addr, e.data);
            end
        end
    endtask

    // Monitor: every bus write and done pulse is matched against the queue.
    always @(negedge clk_in) begin
        if (rst_in === 1'b0) begin
            if (mem_wr)  sb_check(K_WR, mem_a, {24'd0, mem_dout});
            if (if_done) sb_check(K_IF, 32'd0, if_rdata);
            if (ld_done) sb_check(K_LD, 32'd0, ld_rdata);
            if (st_done) sb_check(K_ST, 32'd0, 32'd0);
        end
    end

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic at_neg(input int n);
        goto(n);
        @(negedge clk_in);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int c1;
        rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0; if_abort = 1'b0;
        ld_req = 1'b0; ld_addr = 32'd0; ld_len = 3'd0;
        st_req = 1'b0; st_addr = 32'd0; st_len = 3'd0; st_wdata = 32'd0;

        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("rst_mem_a",    mem_a, 32'd0);
        chk("rst_mem_wr",   {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_dones",    {29'd0, if_done, ld_done, st_done}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_ld_rdata", ld_rdata, 32'd0);

        // Single 4-byte fetch
        goto(cyc + 1);
        c0 = cyc;
        if_req = 1'b1; if_addr = 32'h100;
        push(K_IF, c0 + 4, 32'd0, 32'h0000_0013);
        for (int k = 0; k < 4; k++) begin
            at_neg(c0 + k);
            chk("fetch_mem_a", mem_a, 32'h100 + k);
        end
        goto(c0 + 5);
        if_req = 1'b0;

        // Simultaneous store (2 bytes) and load (1 byte): store wins
        c0 = cyc;
        st_req = 1'b1; st_addr = 32'h200; st_len = 3'd2; st_wdata = 32'hAABB_CCDD;
        ld_req = 1'b1; ld_addr = 32'h300; ld_len = 3'd1;
        push(K_WR, c0,     32'h200, 32'h0000_00DD);
        push(K_WR, c0 + 1, 32'h201, 32'h0000_00CC);
        push(K_ST, c0 + 2, 32'd0,   32'd0);
        push(K_LD, c0 + 4, 32'd0,   32'h0000_005A);
        goto(c0 + 3);
        st_req = 1'b0;
        at_neg(c0 + 3);
        chk("ld_after_st_mem_a", mem_a, 32'h300);
        goto(c0 + 5);
        ld_req = 1'b0;
        at_neg(c0 + 5);
        chk("ld_rdata_hold", ld_rdata, 32'h0000_005A);

        // IO write stalled by a full UART buffer
        goto(cyc + 1);
        c0 = cyc;
        st_req = 1'b1; st_addr = 32'h0003_0000; st_len = 3'd1; st_wdata = 32'h0000_0041;
        io_buffer_full = 1'b1;
        push(K_WR, c0 + 5, 32'h0003_0000, 32'h0000_0041);
        push(K_ST, c0 + 6, 32'd0, 32'd0);
        for (int k = 0; k < 5; k++) begin
            at_neg(c0 + k);
            chk("io_stall_mem_wr", {31'd0, mem_wr}, 32'd0);
            chk("io_stall_mem_a",  mem_a, 32'd0);
        end
        goto(c0 + 5);
        io_buffer_full = 1'b0;
        goto(c0 + 7);
        st_req = 1'b0;

        // Fetch starvation: four loads, then fetch, then the fifth load
        c0 = cyc;
        if_req = 1'b1; if_addr = 32'h100;
        ld_req = 1'b1; ld_addr = 32'h300; ld_len = 3'd1;
        for (int k = 0; k < 4; k++) push(K_LD, c0 + 1 + 2 * k, 32'd0, 32'h0000_005A);
        push(K_IF, c0 + 12, 32'd0, 32'h0000_0013);
        push(K_LD, c0 + 14, 32'd0, 32'h0000_005A);
        at_neg(c0 + 8);
        chk("starve_fetch_mem_a", mem_a, 32'h100);
        goto(c0 + 13);
        if_req = 1'b0;
        goto(c0 + 15);
        ld_req = 1'b0;
        at_neg(c0 + 15);
        chk("if_rdata_hold", if_rdata, 32'h0000_0013);

        // Fetch aborted in its third cycle; pending word load follows
        goto(cyc + 1);
        c0 = cyc;
        if_req = 1'b1; if_addr = 32'h100;
        push(K_LD, c0 + 7, 32'd0, 32'h5958_5B5A);
        goto(c0 + 1);
        ld_req = 1'b1; ld_addr = 32'h300; ld_len = 3'd4;
        goto(c0 + 2);
        if_abort = 1'b1;
        goto(c0 + 3);
        if_abort = 1'b0; if_req = 1'b0;
        at_neg(c0 + 3);
        chk("abort_ld_grant_mem_a", mem_a, 32'h300);
        goto(c0 + 8);
        ld_req = 1'b0;

        // Same word load with a three-cycle freeze in the middle
        goto(c0 + 9);
        c1 = cyc;
        ld_req = 1'b1;
        push(K_LD, c1 + 7, 32'd0, 32'h5958_5B5A);
        goto(c1 + 2);
        rdy_in = 1'b0;
        goto(c1 + 5);
        rdy_in = 1'b1;
        goto(c1 + 8);
        ld_req = 1'b0;

        // Reset in the middle of a 4-byte store
        goto(cyc + 1);
        c0 = cyc;
        st_req = 1'b1; st_addr = 32'h200; st_len = 3'd4; st_wdata = 32'h1122_3344;
        push(K_WR, c0,     32'h200, 32'h0000_0044);
        push(K_WR, c0 + 1, 32'h201, 32'h0000_0033);
        goto(c0 + 2);
        rst_in = 1'b1; st_req = 1'b0;
        goto(c0 + 3);
        rst_in = 1'b0;
        at_neg(c0 + 3);
        chk("post_rst_mem_wr",   {31'd0, mem_wr}, 32'd0);
        chk("post_rst_mem_a",    mem_a, 32'd0);
        chk("post_rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("post_rst_dones",    {29'd0, if_done, ld_done, st_done}, 32'd0);
        chk("post_rst_ld_rdata", ld_rdata, 32'd0);
        goto(c0 + 10);

        chk("sb_drained", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
